cmp_iter_unit: RTL and testbench
================================

# cmp_iter_unit

Multi-cycle, parametrised integer comparator for the execute stage. It compares two N-bit operands W bits per cycle, most-significant chunk first, and terminates early on the first differing chunk. It supports signed, unsigned, equality and inequality modes using RISC-V branch funct3 encoding. The result is returned zero-extended to N bits (SLT-style) over a valid/ready handshake, so the unit serves both SLT/SLTU and branch resolution.

## Interface
Parameters:
- N, 32, operand and result width.
- W, 8, chunk width compared per cycle. N % W == 0 and 1 <= W <= N are required; NCH = N/W.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset; one clock; reset is synchronous and active-high.
- valid_i  in  1  request valid.
- ready_o  out  1  unit can accept a request.
- a_i  in  N  operand a.
- b_i  in  N  operand b.
- op_i  in  3  000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; 010/011 reserved.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts result.
- res_o  out  N  {N-1 zeros, result bit}.

## Operation
FSM states are IDLE, RUN and DONE.
- IDLE:
  - ready_o = 1.
  - Accept on valid_i & ready_o: latch a_i, b_i and op_i; set chunk index idx = NCH-1; go to RUN.
  - For signed ops (LT/GE), bit N-1 of both latched operands is inverted at latch time. This makes the signed compare an unsigned compare.
  - a_i, b_i and op_i are ignored at all other times.
- RUN, one chunk per cycle on bits [idx*W +: W]:
  - If the chunks differ: lt = (a_chunk < b_chunk), eq = 0; go to DONE (early exit).
  - If they are equal and idx == 0: lt = 0, eq = 1; go to DONE.
  - If they are equal and idx > 0: idx <= idx-1; stay in RUN.
- Result bit, registered on the entry to DONE:
  - EQ: eq. NE: ~eq.
  - LT/LTU: lt. GE/GEU: ~lt.
  - Reserved ops: 0.
- DONE:
  - valid_o = 1; res_o holds the result.
  - On ready_i: go to IDLE.
  - ready_o = 0. No request is accepted in DONE, even in the handshake cycle.
- res_o keeps its last value outside DONE. Only the LSB can be 1.
- Reset values: state IDLE, valid_o 0, res_o 0, idx 0. ready_o = (state == IDLE) & ~rst_i, so it is 0 while rst_i is high.
- Reset mid-operation (RUN or DONE): the transaction is aborted with no valid_o pulse. The next cycle shows the reset values.

## Timing
- The accept edge is E0. The RUN edge that terminates on chunk k is Ek, where k = number of chunks examined (1..NCH). valid_o is high from Ek until the handshake edge.
- Latency (accept edge to first valid_o cycle): k+1 cycles. Best case is 2, worst case (equal operands, or a difference only in chunk 0) is NCH+1.
- W = N gives a fixed latency of 2. W = 1 gives a worst case of N+1.
- Throughput: the next accept happens no earlier than one cycle after the result handshake (IDLE cycle).
- Backpressure: while valid_o & ~ready_i, res_o, valid_o and the state are stable.

## Structure
- Package cmp_pkg holds:
  - op encodings (CMP_EQ, CMP_NE, CMP_LT, CMP_GE, CMP_LTU, CMP_GEU);
  - FSM state localparams;
  - the helper function for NCH and the idx width, $clog2(NCH) with a minimum of 1.
- Sub-module cmp_chunk_Wb (parameter W): combinational, inputs a and b, outputs lt and eq. It is instantiated once and fed through the idx-selected slice.
- Top level contains the FSM, operand registers, idx counter and result register.

## Test plan
All cases use N=32, W=8 unless stated otherwise.
1. LT, a=0xFFFFFFFF, b=0x00000001 -> res_o=0x1. Differs in chunk 3; valid_o in the 2nd cycle after accept.
2. LTU with the same operands -> res_o=0x0; latency 2.
3. EQ, a=b=0x12345678 -> res_o=0x1, latency 5. NE with the same operands -> res_o=0x0, latency 5.
4. GE, a=0x80000000, b=0x80000001 -> res_o=0x0. Difference only in chunk 0; latency 5.
5. Backpressure: case 1 with ready_i held low for 3 cycles -> valid_o and res_o=0x1 stay stable and ready_o=0. A valid_i pulse with new operands during the hold is ignored. After the handshake, one IDLE cycle with ready_o=1.
6. Reset in RUN: EQ with a=b=0, rst_i high in the 2nd RUN cycle -> next cycle valid_o=0, res_o=0, ready_o=1, and no result is produced. Repeat case 1 with N=32, W=32 -> latency 2.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared definitions for the iterative comparator: op encodings, FSM states and
// sizing helpers.
package cmp_pkg;

   localparam logic [2:0] CMP_EQ  = 3'b000;
   localparam logic [2:0] CMP_NE  = 3'b001;
   localparam logic [2:0] CMP_LT  = 3'b100;
   localparam logic [2:0] CMP_GE  = 3'b101;
   localparam logic [2:0] CMP_LTU = 3'b110;
   localparam logic [2:0] CMP_GEU = 3'b111;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } cmp_state_e;

   function automatic int unsigned calc_nch(input int unsigned n, input int unsigned w);
      return n / w;
   endfunction

   function automatic int unsigned calc_idx_w(input int unsigned nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction

   // Maps the terminal lt/eq flags onto the single result bit for an op.
   function automatic logic cmp_result(input logic [2:0] op, input logic lt, input logic eq);
      logic r;
      case (op)
         CMP_EQ:           r = eq;
         CMP_NE:           r = ~eq;
         CMP_LT, CMP_LTU:  r = lt;
         CMP_GE, CMP_GEU:  r = ~lt;
         default:          r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/cmp_chunk_Wb.sv
// Combinational unsigned compare of one W-bit chunk.
module cmp_chunk_Wb #(
   parameter int unsigned W = 8
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic         lt_o,
   output logic         eq_o
);

   assign lt_o = (a_i < b_i);
   assign eq_o = (a_i == b_i);

endmodule

// File: rtl/cmp_iter_unit.sv
// Multi-cycle comparator: walks the operands W bits per cycle from the top chunk
// down and stops at the first differing chunk. Result is SLT-style, zero-extended.
module cmp_iter_unit
   import cmp_pkg::*;
#(
   parameter int unsigned N = 32,
   parameter int unsigned W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         valid_i,
   output logic         ready_o,
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic [2:0]   op_i,
   output logic         valid_o,
   input  logic         ready_i,
   output logic [N-1:0] res_o
);

   localparam int unsigned NCH = calc_nch(N, W);
   localparam int unsigned IW  = calc_idx_w(NCH);
   localparam logic [IW-1:0] IdxLast = IW'(NCH - 1);

   cmp_state_e    state_q, state_d;
   logic [N-1:0]  a_q, a_d;
   logic [N-1:0]  b_q, b_d;
   logic [2:0]    op_q, op_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [N-1:0]  res_q, res_d;

   logic [W-1:0]  a_ch, b_ch;
   logic          ch_lt, ch_eq;

   always_comb begin
      a_ch = '0;
      b_ch = '0;
      for (int i = 0; i < int'(NCH); i++) begin
         if (idx_q == IW'(i)) begin
            a_ch = a_q[i*W +: W];
            b_ch = b_q[i*W +: W];
         end
      end
   end

   cmp_chunk_Wb #(
      .W (W)
   ) u_chunk (
      .a_i  (a_ch),
      .b_i  (b_ch),
      .lt_o (ch_lt),
      .eq_o (ch_eq)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      idx_d   = idx_q;
      res_d   = res_q;
      case (state_q)
         StIdle: begin
            if (valid_i) begin
               a_d   = a_i;
               b_d   = b_i;
               op_d  = op_i;
               idx_d = IdxLast;
               // Flipping the sign bits turns a signed compare into an unsigned one.
               if (op_i == CMP_LT || op_i == CMP_GE) begin
                  a_d[N-1] = ~a_i[N-1];
                  b_d[N-1] = ~b_i[N-1];
               end
               state_d = StRun;
            end
         end
         StRun: begin
            if (!ch_eq || idx_q == '0) begin
               res_d    = '0;
               res_d[0] = cmp_result(op_q, ch_lt, ch_eq);
               state_d  = StDone;
            end else begin
               idx_d = idx_q - 1'b1;
            end
         end
         StDone: begin
            if (ready_i) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         idx_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         idx_q   <= idx_d;
         res_q   <= res_d;
      end
   end

   assign ready_o = (state_q == StIdle) & ~rst_i;
   assign valid_o = (state_q == StDone);
   assign res_o   = res_q;

endmodule

// File: tb/tb_cmp_iter_unit.sv
// Randomised and directed checks of cmp_iter_unit (W=8 and W=32 instances)
// against a behavioural compare/latency model.
module tb_cmp_iter_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [2:0]  op = '0;

   logic        valid_n = 1'b0, rdy_in_n = 1'b0, ready_o_n, valid_o_n;
   logic        valid_w = 1'b0, rdy_in_w = 1'b0, ready_o_w, valid_o_w;
   logic [31:0] res_n, res_w;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cmp_iter_unit #(.N(32), .W(8)) dut_n (
      .clk_i   (clk),
      .rst_i   (rst),
      .valid_i (valid_n),
      .ready_o (ready_o_n),
      .a_i     (a),
      .b_i     (b),
      .op_i    (op),
      .valid_o (valid_o_n),
      .ready_i (rdy_in_n),
      .res_o   (res_n)
   );

   cmp_iter_unit #(.N(32), .W(32)) dut_w (
      .clk_i   (clk),
      .rst_i   (rst),
      .valid_i (valid_w),
      .ready_o (ready_o_w),
      .a_i     (a),
      .b_i     (b),
      .op_i    (op),
      .valid_o (valid_o_w),
      .ready_i (rdy_in_w),
      .res_o   (res_w)
   );

   function automatic logic [31:0] exp_res(input logic [31:0] x, input logic [31:0] y,
                                           input logic [2:0] o);
      logic r;
      case (o)
         3'b000:  r = (x == y);
         3'b001:  r = (x != y);
         3'b100:  r = ($signed(x) < $signed(y));
         3'b101:  r = ($signed(x) >= $signed(y));
         3'b110:  r = (x < y);
         3'b111:  r = (x >= y);
         default: r = 1'b0;
      endcase
      return {31'b0, r};
   endfunction

   // Cycles from accept to first valid: 1 + chunks examined (top chunk first).
   function automatic int exp_lat(input logic [31:0] x, input logic [31:0] y, input int w);
      int nch;
      logic [63:0] diff, mask;
      nch  = 32 / w;
      diff = {32'b0, x ^ y};
      mask = (64'h1 << w) - 64'h1;
      for (int c = nch - 1; c >= 0; c--) begin
         if (((diff >> (c * w)) & mask) != 64'h0) return (nch - c) + 1;
      end
      return nch + 1;
   endfunction

   function automatic logic cur_valid(input bit wide);
      return wide ? valid_o_w : valid_o_n;
   endfunction

   function automatic logic cur_ready(input bit wide);
      return wide ? ready_o_w : ready_o_n;
   endfunction

   function automatic logic [31:0] cur_res(input bit wide);
      return wide ? res_w : res_n;
   endfunction

   task automatic set_valid(input bit wide, input logic v);
      if (wide) valid_w = v;
      else valid_n = v;
   endtask

   task automatic set_rdy(input bit wide, input logic v);
      if (wide) rdy_in_w = v;
      else rdy_in_n = v;
   endtask

   task automatic do_txn(input bit wide, input logic [31:0] ta, input logic [31:0] tb,
                         input logic [2:0] top, input string name);
      int lat, el;
      logic [31:0] er;
      er = exp_res(ta, tb, top);
      el = exp_lat(ta, tb, wide ? 32 : 8);
      a = ta;
      b = tb;
      op = top;
      set_valid(wide, 1'b1);
      checks++;
      if (cur_ready(wide) !== 1'b1) begin
         errors++;
         $display("FAIL %s ready_o before accept: got %b want 1", name, cur_ready(wide));
      end
      @(posedge clk);
      #1;
      set_valid(wide, 1'b0);
      a = $urandom;
      b = $urandom;
      op = 3'($urandom);
      lat = 1;
      while (cur_valid(wide) !== 1'b1 && lat < 64) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checks++;
      if (lat != el) begin
         errors++;
         $display("FAIL %s latency: got %0d want %0d (a=%h b=%h op=%b)", name, lat, el, ta, tb,
                  top);
      end
      checks++;
      if (cur_res(wide) !== er) begin
         errors++;
         $display("FAIL %s res_o: got %h want %h (a=%h b=%h op=%b)", name, cur_res(wide), er, ta,
                  tb, top);
      end
      checks++;
      if (cur_ready(wide) !== 1'b0) begin
         errors++;
         $display("FAIL %s ready_o while result pending: got %b want 0", name, cur_ready(wide));
      end
      set_rdy(wide, 1'b1);
      @(posedge clk);
      #1;
      set_rdy(wide, 1'b0);
      checks++;
      if (cur_valid(wide) !== 1'b0 || cur_ready(wide) !== 1'b1) begin
         errors++;
         $display("FAIL %s after handshake valid_o/ready_o: got %b/%b want 0/1", name,
                  cur_valid(wide), cur_ready(wide));
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (ready_o_n !== 1'b0 || valid_o_n !== 1'b0) begin
         errors++;
         $display("FAIL reset_held ready_o/valid_o: got %b/%b want 0/0", ready_o_n, valid_o_n);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (ready_o_n !== 1'b1 || res_n !== 32'h0 || valid_o_n !== 1'b0 || ready_o_w !== 1'b1) begin
         errors++;
         $display("FAIL reset_release ready/res/valid/ready_w: got %b/%h/%b/%b want 1/0/0/1",
                  ready_o_n, res_n, valid_o_n, ready_o_w);
      end
   endtask

   task automatic test_directed();
      do_txn(1'b0, 32'hFFFFFFFF, 32'h00000001, 3'b100, "lt_signed");
      do_txn(1'b0, 32'hFFFFFFFF, 32'h00000001, 3'b110, "ltu");
      do_txn(1'b0, 32'h12345678, 32'h12345678, 3'b000, "eq_equal");
      do_txn(1'b0, 32'h12345678, 32'h12345678, 3'b001, "ne_equal");
      do_txn(1'b0, 32'h80000000, 32'h80000001, 3'b101, "ge_chunk0");
      do_txn(1'b0, 32'h00000005, 32'h00000003, 3'b010, "reserved");
   endtask

   task automatic test_backpressure();
      a = 32'hFFFFFFFF;
      b = 32'h00000001;
      op = 3'b100;
      valid_n = 1'b1;
      @(posedge clk);
      #1;
      valid_n = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         if (i == 1) begin
            a = 32'h0;
            b = 32'h0;
            op = 3'b001;
            valid_n = 1'b1;
         end
         checks++;
         if (valid_o_n !== 1'b1 || res_n !== 32'h1 || ready_o_n !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold%0d valid/res/ready: got %b/%h/%b want 1/00000001/0", i,
                     valid_o_n, res_n, ready_o_n);
         end
         @(posedge clk);
         #1;
         valid_n = 1'b0;
      end
      // Request held through the handshake cycle must not be taken.
      a = 32'h0;
      b = 32'h0;
      op = 3'b000;
      valid_n = 1'b1;
      rdy_in_n = 1'b1;
      @(posedge clk);
      #1;
      valid_n = 1'b0;
      rdy_in_n = 1'b0;
      checks++;
      if (ready_o_n !== 1'b1 || valid_o_n !== 1'b0) begin
         errors++;
         $display("FAIL bp_idle ready/valid: got %b/%b want 1/0", ready_o_n, valid_o_n);
      end
      @(posedge clk);
      #1;
      checks++;
      if (ready_o_n !== 1'b1 || res_n !== 32'h1) begin
         errors++;
         $display("FAIL bp_no_accept ready/res: got %b/%h want 1/00000001", ready_o_n, res_n);
      end
   endtask

   task automatic test_reset_in_run();
      do_txn(1'b0, 32'hCAFEF00D, 32'hCAFEF00D, 3'b000, "pre_reset_eq");
      a = 32'h0;
      b = 32'h0;
      op = 3'b000;
      valid_n = 1'b1;
      @(posedge clk);
      #1;
      valid_n = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (ready_o_n !== 1'b0) begin
         errors++;
         $display("FAIL rst_run ready_o during reset: got %b want 0", ready_o_n);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checks++;
      if (valid_o_n !== 1'b0 || res_n !== 32'h0 || ready_o_n !== 1'b1) begin
         errors++;
         $display("FAIL rst_run after valid/res/ready: got %b/%h/%b want 0/0/1", valid_o_n,
                  res_n, ready_o_n);
      end
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (valid_o_n !== 1'b0 || ready_o_n !== 1'b1) begin
            errors++;
            $display("FAIL rst_run_quiet%0d valid/ready: got %b/%b want 0/1", i, valid_o_n,
                     ready_o_n);
         end
      end
   endtask

   task automatic test_wide();
      do_txn(1'b1, 32'hFFFFFFFF, 32'h00000001, 3'b100, "wide_lt");
      do_txn(1'b1, 32'h12345678, 32'h12345678, 3'b000, "wide_eq");
      do_txn(1'b1, 32'h80000000, 32'h80000001, 3'b101, "wide_ge");
   endtask

   task automatic test_random(input bit wide, input int count);
      logic [31:0] ra, rb, diff;
      int p;
      for (int i = 0; i < count; i++) begin
         ra = $urandom;
         p = $urandom_range(0, 4);
         if (p == 4) begin
            rb = ra;
         end else begin
            diff = (32'($urandom_range(1, 255)) << (p * 8)) |
                   ($urandom & ((32'h1 << (p * 8)) - 32'h1));
            rb = ra ^ diff;
         end
         do_txn(wide, ra, rb, 3'($urandom_range(0, 7)), wide ? "rand_wide" : "rand_narrow");
      end
   endtask

   task automatic test_back_to_back();
      do_txn(1'b0, 32'h7FFFFFFF, 32'h80000000, 3'b100, "b2b_lt");
      do_txn(1'b0, 32'h7FFFFFFF, 32'h80000000, 3'b111, "b2b_geu");
      do_txn(1'b0, 32'h00000100, 32'h00000101, 3'b110, "b2b_ltu");
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_in_run();
      test_wide();
      test_back_to_back();
      test_random(1'b0, 40);
      test_random(1'b1, 10);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
